// File: rtl/register_file_pkg.sv
// Shared constants for the MSP430 register file: register indices, SR bit
// positions and the flag bundle carried by the execute stage.
package register_file_pkg;

  localparam int NUM_REGS = 16;

  localparam logic [3:0] REG_PC  = 4'd0;
  localparam logic [3:0] REG_SP  = 4'd1;
  localparam logic [3:0] REG_SR  = 4'd2;
  localparam logic [3:0] REG_CG2 = 4'd3;
  localparam logic [3:0] REG_R4  = 4'd4;
  localparam logic [3:0] REG_R15 = 4'd15;

  localparam int SR_C    = 0;
  localparam int SR_Z    = 1;
  localparam int SR_N    = 2;
  localparam int SR_GIE  = 3;
  localparam int SR_SCG0 = 6;
  localparam int SR_V    = 8;

  // Only SCG0 survives an interrupt acknowledge.
  localparam logic [15:0] SR_INTACK_KEEP = 16'(1 << SR_SCG0);

  typedef struct packed {
    logic v;
    logic n;
    logic z;
    logic c;
  } flags_t;

endpackage

// File: rtl/register_file_if.sv
// Control/data bundle between the decode FSM / ALU and the register file.
// master = CPU control side, slave = register file.
interface register_file_if;
  logic        IdxF;
  logic        IF;
  logic        SPF;
  logic        INTACK;
  logic        Ex;
  logic [3:0]  SRnew;
  logic [3:0]  srcA;
  logic [3:0]  dstA;
  logic        IW6;
  logic        srcInc;
  logic        dstInc;
  logic        RW;
  logic [15:0] result;
  logic [15:0] ISR;
  logic [15:0] PCout;
  logic [15:0] SPout;
  logic [15:0] Rsrc;
  logic [15:0] Rdst;
  logic [3:0]  SRcurrent;
  logic        GIE;

  modport master (
    output IdxF, IF, SPF, INTACK, Ex, SRnew, srcA, dstA, IW6,
           srcInc, dstInc, RW, result, ISR,
    input  PCout, SPout, Rsrc, Rdst, SRcurrent, GIE
  );

  modport slave (
    input  IdxF, IF, SPF, INTACK, Ex, SRnew, srcA, dstA, IW6,
           srcInc, dstInc, RW, result, ISR,
    output PCout, SPout, Rsrc, Rdst, SRcurrent, GIE
  );
endinterface

// File: rtl/register_file_sr_unit.sv
// Status register (R2) owner: merges execute-stage flags, handles explicit
// write-back and the interrupt-acknowledge clear, and exposes flags and GIE.
module register_file_sr_unit
  import register_file_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        intack,
  input  logic        ex,
  input  logic [3:0]  srnew,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic [15:0] sr,
  output logic [3:0]  flags,
  output logic        gie
);

  flags_t newf;
  assign newf = flags_t'(srnew);

  // SR update: interrupt acknowledge beats write-back, which beats flag merge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr <= '0;
    end else if (intack) begin
      sr <= sr & SR_INTACK_KEEP;
    end else if (wr_en) begin
      sr <= wr_data;
    end else if (ex) begin
      sr[SR_V] <= newf.v;
      sr[SR_N] <= newf.n;
      sr[SR_Z] <= newf.z;
      sr[SR_C] <= newf.c;
    end
  end

  assign flags = {sr[SR_V], sr[SR_N], sr[SR_Z], sr[SR_C]};
  assign gie   = sr[SR_GIE];

endmodule

// File: rtl/register_file.sv
// MSP430 register file R0..R15 with combinational src/dst read ports,
// write-back, autoincrement and fetch/push/interrupt side effects.
// Optional build macro: REGFILE_CG_EN (constant-generator view of R3/R2 on Rsrc).
module register_file
  import register_file_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h4400,
  parameter logic [15:0] RESET_SP = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  register_file_if.slave  bus
);

  logic [15:0]         regs [NUM_REGS];
  logic [15:0]         wdata;
  logic [15:0]         gen_step;
  logic [NUM_REGS-1:0] wr_sel;
  logic [NUM_REGS-1:0] inc_sel;
  logic [15:0]         sr;
  logic [3:0]          sr_flags;
  logic                sr_gie;

  // Decode write-back data, increment step and per-register write/increment hits.
  always_comb begin
    wdata    = bus.IW6 ? {8'h00, bus.result[7:0]} : bus.result;
    gen_step = bus.IW6 ? 16'd1 : 16'd2;
    wr_sel   = '0;
    inc_sel  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i]  = bus.RW && (bus.dstA == 4'(i));
      inc_sel[i] = (bus.srcInc && (bus.srcA == 4'(i))) ||
                   (bus.dstInc && (bus.dstA == 4'(i)));
    end
  end

  register_file_sr_unit u_sr (
    .clk     (clk),
    .rst     (rst),
    .intack  (bus.INTACK),
    .ex      (bus.Ex),
    .srnew   (bus.SRnew),
    .wr_en   (wr_sel[REG_SR]),
    .wr_data (wdata),
    .sr      (sr),
    .flags   (sr_flags),
    .gie     (sr_gie)
  );

  // Register array update; R2 lives in the SR unit and R3 is hard zero,
  // so their array slots are held at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      regs[REG_PC] <= RESET_PC;
      regs[REG_SP] <= RESET_SP;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == int'(REG_PC)) begin
          if (bus.INTACK) begin
            regs[i] <= bus.ISR & 16'hFFFE;
          end else if (wr_sel[i]) begin
            regs[i] <= wdata & 16'hFFFE;
          end else if (inc_sel[i]) begin
            regs[i] <= regs[i] + 16'd2;
          end else if (bus.IF || bus.IdxF) begin
            regs[i] <= regs[i] + 16'd2;
          end
        end else if (i == int'(REG_SP)) begin
          if (wr_sel[i]) begin
            regs[i] <= wdata & 16'hFFFE;
          end else if (inc_sel[i]) begin
            regs[i] <= regs[i] + 16'd2;
          end else if (bus.SPF) begin
            regs[i] <= regs[i] - 16'd2;
          end
        end else if (i == int'(REG_SR) || i == int'(REG_CG2)) begin
          regs[i] <= '0;
        end else begin
          if (wr_sel[i]) begin
            regs[i] <= wdata;
          end else if (inc_sel[i]) begin
            regs[i] <= regs[i] + gen_step;
          end
        end
      end
    end
  end

  // Source read port; the constant-generator build decodes R3/R2 explicitly.
  always_comb begin
`ifdef REGFILE_CG_EN
    case (bus.srcA)
      REG_CG2: bus.Rsrc = 16'h0000;
      REG_SR:  bus.Rsrc = sr;
      default: bus.Rsrc = regs[bus.srcA];
    endcase
`else
    if (bus.srcA == REG_SR) begin
      bus.Rsrc = sr;
    end else begin
      bus.Rsrc = regs[bus.srcA];
    end
`endif
  end

  // Destination read port; R3 always reads as zero.
  always_comb begin
    case (bus.dstA)
      REG_CG2: bus.Rdst = 16'h0000;
      REG_SR:  bus.Rdst = sr;
      default: bus.Rdst = regs[bus.dstA];
    endcase
  end

  assign bus.PCout     = regs[REG_PC];
  assign bus.SPout     = regs[REG_SP];
  assign bus.SRcurrent = sr_flags;
  assign bus.GIE       = sr_gie;

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: directed scenarios plus randomized traffic
// compared against an operation-level reference model.
module tb_register_file;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  register_file_if bus ();

  register_file #(
    .RESET_PC (16'h4400),
    .RESET_SP (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Architectural view of R0..R15; index 2 holds SR, index 3 stays zero.
  logic [15:0] mregs [16];

  function automatic logic [15:0] mread(input logic [3:0] idx);
    return (idx == 4'd3) ? 16'h0000 : mregs[idx];
  endfunction

  task automatic clear_inputs();
    bus.IdxF   = 1'b0;
    bus.IF     = 1'b0;
    bus.SPF    = 1'b0;
    bus.INTACK = 1'b0;
    bus.Ex     = 1'b0;
    bus.SRnew  = 4'h0;
    bus.srcA   = 4'd4;
    bus.dstA   = 4'd5;
    bus.IW6    = 1'b0;
    bus.srcInc = 1'b0;
    bus.dstInc = 1'b0;
    bus.RW     = 1'b0;
    bus.result = 16'h0000;
    bus.ISR    = 16'h0000;
  endtask

  // Applies the cycle's operations lowest priority first, each later one
  // overwriting, all computed from the pre-edge state.
  task automatic model_step();
    logic [15:0] old [16];
    logic [15:0] nxt [16];
    logic [15:0] v;
    logic        en;
    int          r;
    old = mregs;
    nxt = mregs;
    if (bus.IF || bus.IdxF) nxt[0] = old[0] + 16'd2;
    if (bus.SPF) nxt[1] = old[1] - 16'd2;
    if (bus.Ex) begin
      nxt[2][8] = bus.SRnew[3];
      nxt[2][2] = bus.SRnew[2];
      nxt[2][1] = bus.SRnew[1];
      nxt[2][0] = bus.SRnew[0];
    end
    for (int k = 0; k < 2; k++) begin
      en = (k == 0) ? bus.srcInc : bus.dstInc;
      r  = (k == 0) ? int'(bus.srcA) : int'(bus.dstA);
      if (en && r != 2 && r != 3)
        nxt[r] = old[r] + ((r < 2 || !bus.IW6) ? 16'd2 : 16'd1);
    end
    if (bus.RW && bus.dstA != 4'd3) begin
      v = bus.IW6 ? (bus.result & 16'h00FF) : bus.result;
      if (bus.dstA < 4'd2) v[0] = 1'b0;
      nxt[bus.dstA] = v;
    end
    if (bus.INTACK) begin
      nxt[0] = bus.ISR & 16'hFFFE;
      nxt[2] = old[2] & 16'h0040;
    end
    mregs = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 16; i++) mregs[i] = 16'h0000;
      mregs[0] = 16'h4400;
      mregs[1] = 16'h0000;
    end else begin
      model_step();
    end
    #1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst = 1'b0;
    clear_inputs();
    repeat (3) tick();
    rst = 1'b1;
    #1;
    total++; if (bus.PCout !== 16'h4400) begin bad++; $display("[TB] FAIL reset_pc got=%h want=%h", bus.PCout, 16'h4400); end
    total++; if (bus.SPout !== 16'h0000) begin bad++; $display("[TB] FAIL reset_sp got=%h want=%h", bus.SPout, 16'h0000); end
    total++; if (bus.Rsrc !== 16'h0000) begin bad++; $display("[TB] FAIL reset_r4 got=%h want=%h", bus.Rsrc, 16'h0000); end
    total++; if (bus.Rdst !== 16'h0000) begin bad++; $display("[TB] FAIL reset_r5 got=%h want=%h", bus.Rdst, 16'h0000); end
    bus.srcA = 4'd2;
    #1;
    total++; if (bus.Rsrc !== 16'h0000) begin bad++; $display("[TB] FAIL reset_sr got=%h want=%h", bus.Rsrc, 16'h0000); end
  endtask

  task automatic test_intack_fetch();
    $display("[TB] test_intack_fetch");
    clear_inputs();
    bus.srcA = 4'd2; bus.INTACK = 1'b1; bus.ISR = 16'h4456;
    tick();
    total++; if (bus.PCout !== 16'h4456) begin bad++; $display("[TB] FAIL intack_pc got=%h want=%h", bus.PCout, 16'h4456); end
    total++; if (bus.Rsrc !== 16'h0000) begin bad++; $display("[TB] FAIL intack_sr got=%h want=%h", bus.Rsrc, 16'h0000); end
    clear_inputs(); bus.IdxF = 1'b1;
    tick();
    total++; if (bus.PCout !== 16'h4458) begin bad++; $display("[TB] FAIL idxf_pc got=%h want=%h", bus.PCout, 16'h4458); end
    clear_inputs(); bus.IF = 1'b1; bus.IdxF = 1'b1;
    tick();
    total++; if (bus.PCout !== 16'h445A) begin bad++; $display("[TB] FAIL if_pc got=%h want=%h", bus.PCout, 16'h445A); end
  endtask

  task automatic test_stack_flags();
    $display("[TB] test_stack_flags");
    clear_inputs(); bus.SPF = 1'b1;
    tick();
    total++; if (bus.SPout !== 16'hFFFE) begin bad++; $display("[TB] FAIL spf_wrap got=%h want=%h", bus.SPout, 16'hFFFE); end
    clear_inputs(); bus.srcA = 4'd2; bus.Ex = 1'b1; bus.SRnew = 4'b1010;
    tick();
    total++; if (bus.Rsrc !== 16'h0102) begin bad++; $display("[TB] FAIL ex_sr got=%h want=%h", bus.Rsrc, 16'h0102); end
    total++; if (bus.SRcurrent !== 4'b1010) begin bad++; $display("[TB] FAIL ex_flags got=%b want=%b", bus.SRcurrent, 4'b1010); end
  endtask

  task automatic test_write();
    $display("[TB] test_write");
    clear_inputs(); bus.RW = 1'b1; bus.result = 16'h89AB; bus.dstA = 4'd4;
    tick();
    total++; if (bus.Rdst !== 16'h89AB) begin bad++; $display("[TB] FAIL wr_r4 got=%h want=%h", bus.Rdst, 16'h89AB); end
    bus.dstA = 4'd0;
    tick();
    total++; if (bus.PCout !== 16'h89AA) begin bad++; $display("[TB] FAIL wr_pc got=%h want=%h", bus.PCout, 16'h89AA); end
    bus.dstA = 4'd3; bus.srcA = 4'd3;
    tick();
    total++; if (bus.Rsrc !== 16'h0000) begin bad++; $display("[TB] FAIL wr_r3 got=%h want=%h", bus.Rsrc, 16'h0000); end
    bus.dstA = 4'd2;
    tick();
    total++; if (bus.GIE !== 1'b1) begin bad++; $display("[TB] FAIL wr_sr_gie got=%b want=%b", bus.GIE, 1'b1); end
    total++; if (bus.Rdst !== 16'h89AB) begin bad++; $display("[TB] FAIL wr_sr got=%h want=%h", bus.Rdst, 16'h89AB); end
    bus.dstA = 4'd4; bus.IW6 = 1'b1;
    tick();
    total++; if (bus.Rdst !== 16'h00AB) begin bad++; $display("[TB] FAIL wr_byte got=%h want=%h", bus.Rdst, 16'h00AB); end
  endtask

  task automatic test_increment();
    $display("[TB] test_increment");
    clear_inputs(); bus.srcInc = 1'b1; bus.srcA = 4'd4;
    tick();
    total++; if (bus.Rsrc !== 16'h00AD) begin bad++; $display("[TB] FAIL inc_word got=%h want=%h", bus.Rsrc, 16'h00AD); end
    bus.IW6 = 1'b1;
    tick();
    total++; if (bus.Rsrc !== 16'h00AE) begin bad++; $display("[TB] FAIL inc_byte got=%h want=%h", bus.Rsrc, 16'h00AE); end
    clear_inputs(); bus.dstInc = 1'b1; bus.dstA = 4'd0; bus.IW6 = 1'b1;
    tick();
    total++; if (bus.PCout !== 16'h89AC) begin bad++; $display("[TB] FAIL inc_pc got=%h want=%h", bus.PCout, 16'h89AC); end
    clear_inputs(); bus.srcInc = 1'b1; bus.srcA = 4'd2; bus.dstInc = 1'b1; bus.dstA = 4'd3;
    tick();
    total++; if (bus.Rsrc !== 16'h89AB) begin bad++; $display("[TB] FAIL inc_sr got=%h want=%h", bus.Rsrc, 16'h89AB); end
    total++; if (bus.Rdst !== 16'h0000) begin bad++; $display("[TB] FAIL inc_r3 got=%h want=%h", bus.Rdst, 16'h0000); end
    clear_inputs(); bus.srcInc = 1'b1; bus.dstInc = 1'b1; bus.srcA = 4'd4; bus.dstA = 4'd4;
    tick();
    total++; if (bus.Rdst !== 16'h00B0) begin bad++; $display("[TB] FAIL inc_single got=%h want=%h", bus.Rdst, 16'h00B0); end
    clear_inputs(); bus.srcInc = 1'b1; bus.srcA = 4'd1; bus.IW6 = 1'b1;
    tick();
    total++; if (bus.SPout !== 16'h0000) begin bad++; $display("[TB] FAIL inc_sp got=%h want=%h", bus.SPout, 16'h0000); end
  endtask

  task automatic test_priority();
    $display("[TB] test_priority");
    clear_inputs(); bus.RW = 1'b1; bus.dstA = 4'd0; bus.result = 16'h1235; bus.IF = 1'b1;
    tick();
    total++; if (bus.PCout !== 16'h1234) begin bad++; $display("[TB] FAIL rw_over_if got=%h want=%h", bus.PCout, 16'h1234); end
    clear_inputs(); bus.RW = 1'b1; bus.dstA = 4'd1; bus.result = 16'h3333; bus.SPF = 1'b1;
    tick();
    total++; if (bus.SPout !== 16'h3332) begin bad++; $display("[TB] FAIL rw_over_spf got=%h want=%h", bus.SPout, 16'h3332); end
    clear_inputs(); bus.RW = 1'b1; bus.dstA = 4'd2; bus.result = 16'h00C5;
    tick();
    clear_inputs(); bus.srcA = 4'd2; bus.INTACK = 1'b1; bus.ISR = 16'h6001; bus.Ex = 1'b1; bus.SRnew = 4'b1111;
    bus.RW = 1'b1; bus.dstA = 4'd0; bus.result = 16'h7777;
    tick();
    total++; if (bus.Rsrc !== 16'h0040) begin bad++; $display("[TB] FAIL intack_over_ex got=%h want=%h", bus.Rsrc, 16'h0040); end
    total++; if (bus.PCout !== 16'h6000) begin bad++; $display("[TB] FAIL intack_over_rw got=%h want=%h", bus.PCout, 16'h6000); end
  endtask

  task automatic test_reset_midop();
    $display("[TB] test_reset_midop");
    clear_inputs(); bus.RW = 1'b1; bus.dstA = 4'd4; bus.result = 16'hBEEF;
    bus.IF = 1'b1; bus.SPF = 1'b1; bus.INTACK = 1'b1; bus.ISR = 16'h1000;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    total++; if (bus.PCout !== 16'h4400) begin bad++; $display("[TB] FAIL midrst_pc got=%h want=%h", bus.PCout, 16'h4400); end
    total++; if (bus.SPout !== 16'h0000) begin bad++; $display("[TB] FAIL midrst_sp got=%h want=%h", bus.SPout, 16'h0000); end
    total++; if (bus.Rdst !== 16'h0000) begin bad++; $display("[TB] FAIL midrst_r4 got=%h want=%h", bus.Rdst, 16'h0000); end
  endtask

  task automatic test_random();
    logic [15:0] es, ed;
    logic [3:0]  ef;
    $display("[TB] test_random");
    for (int n = 0; n < 400; n++) begin
      bus.IdxF   = ($urandom_range(0, 3) == 0);
      bus.IF     = ($urandom_range(0, 2) == 0);
      bus.SPF    = ($urandom_range(0, 3) == 0);
      bus.INTACK = ($urandom_range(0, 15) == 0);
      bus.Ex     = ($urandom_range(0, 2) == 0);
      bus.SRnew  = 4'($urandom);
      bus.srcA   = 4'($urandom);
      bus.dstA   = 4'($urandom);
      bus.IW6    = 1'($urandom);
      bus.srcInc = ($urandom_range(0, 2) == 0);
      bus.dstInc = ($urandom_range(0, 2) == 0);
      bus.RW     = ($urandom_range(0, 2) == 0);
      bus.result = 16'($urandom);
      bus.ISR    = 16'($urandom);
      rst        = ($urandom_range(0, 63) != 0);
      tick();
      rst = 1'b1;
      #1;
      es = mread(bus.srcA);
      ed = mread(bus.dstA);
      ef = {mregs[2][8], mregs[2][2], mregs[2][1], mregs[2][0]};
      total++; if (bus.PCout !== mregs[0]) begin bad++; $display("[TB] FAIL rnd_pc n=%0d got=%h want=%h", n, bus.PCout, mregs[0]); end
      total++; if (bus.SPout !== mregs[1]) begin bad++; $display("[TB] FAIL rnd_sp n=%0d got=%h want=%h", n, bus.SPout, mregs[1]); end
      total++; if (bus.Rsrc !== es) begin bad++; $display("[TB] FAIL rnd_src n=%0d r=%0d got=%h want=%h", n, bus.srcA, bus.Rsrc, es); end
      total++; if (bus.Rdst !== ed) begin bad++; $display("[TB] FAIL rnd_dst n=%0d r=%0d got=%h want=%h", n, bus.dstA, bus.Rdst, ed); end
      total++; if (bus.SRcurrent !== ef) begin bad++; $display("[TB] FAIL rnd_flags n=%0d got=%b want=%b", n, bus.SRcurrent, ef); end
      total++; if (bus.GIE !== mregs[2][3]) begin bad++; $display("[TB] FAIL rnd_gie n=%0d got=%b want=%b", n, bus.GIE, mregs[2][3]); end
    end
    clear_inputs();
    for (int i = 0; i < 16; i++) begin
      bus.srcA = 4'(i);
      bus.dstA = 4'(15 - i);
      #1;
      es = mread(bus.srcA);
      ed = mread(bus.dstA);
      total++; if (bus.Rsrc !== es) begin bad++; $display("[TB] FAIL sweep_src r=%0d got=%h want=%h", i, bus.Rsrc, es); end
      total++; if (bus.Rdst !== ed) begin bad++; $display("[TB] FAIL sweep_dst r=%0d got=%h want=%h", 15 - i, bus.Rdst, ed); end
    end
  endtask

  initial begin
    test_reset();
    test_intack_fetch();
    test_stack_flags();
    test_write();
    test_increment();
    test_priority();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
